// File: rtl/ov7670_emu_pkg.sv
// Shared types and helpers for the OV7670 frame emulator.
//   state_t   : vertical frame sequencer states
//   pattern_t : selectable test-pattern encodings (matches pattern_sel)
//   cnt_width : counter width for a count of n, never narrower than 1 bit
//   max4      : largest of four integers, used to size the shared line counter
package ov7670_emu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    BACK   = 3'd2,
    ACTIVE = 3'd3,
    FRONT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_XRAMP = 2'd0,
    PAT_YRAMP = 2'd1,
    PAT_CONST = 2'd2,
    PAT_XOR   = 2'd3
  } pattern_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ov7670_frame_emulator_if.sv
// OV7670 parallel video port as seen on the camera connector.
//   PCLK  : pixel clock
//   VSYNC : frame sync, active high
//   HREF  : line valid, active high
//   D     : 8-bit pixel byte
// master = sensor side (drives), slave = capture side (receives).
interface ov7670_frame_emulator_if;
  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] D;

  modport master (output PCLK, output VSYNC, output HREF, output D);
  modport slave  (input  PCLK, input  VSYNC, input  HREF, input  D);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern byte generator.
//   pattern     : pattern selector
//   x, y        : low bytes of pixel index and active-line index
//   const_value : byte emitted by the constant pattern
//   frame_count : completed-frame counter, mixed into the XOR pattern
//   value       : resulting pixel byte
module ov7670_pattern_gen
  import ov7670_emu_pkg::*;
(
  input  pattern_t   pattern,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] const_value,
  input  logic [7:0] frame_count,
  output logic [7:0] value
);

  always_comb begin
    value = 8'h00;
    case (pattern)
      PAT_XRAMP: value = x;
      PAT_YRAMP: value = y;
      PAT_CONST: value = const_value;
      PAT_XOR:   value = x ^ frame_count;
      default:   value = 8'h00;
    endcase
  end

endmodule

// File: rtl/ov7670_frame_emulator.sv
// Transmit-side OV7670 video port model. Produces PCLK (clk/2), VSYNC, HREF
// and raw 8-bit D with selectable test patterns so the capture path can run
// without a sensor.
//   clk          : system clock, only clock
//   reset_       : asynchronous active-low reset
//   enable       : keep producing frames while high
//   pattern_sel  : 0 x ramp, 1 y ramp, 2 constant, 3 x ^ frame_count
//   const_value  : byte for the constant pattern
//   cam          : video port (PCLK/VSYNC/HREF/D), master side
//   frame_done   : one-clk pulse on the last tick of each frame
//   frame_count  : completed-frame counter, wraps at 256
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no frame; waits for enable on a tick
// SYNC   | VSYNC high for VSYNC_LINES lines
// BACK   | V_BACK blank lines after VSYNC
// ACTIVE | V_ACTIVE lines, HREF high for first H_ACTIVE PCLKs of each
// FRONT  | V_FRONT blank lines, then SYNC (enable) or IDLE
module ov7670_frame_emulator
  import ov7670_emu_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    enable,
  input  logic [1:0]              pattern_sel,
  input  logic [7:0]              const_value,
  ov7670_frame_emulator_if.master cam,
  output logic                    frame_done,
  output logic [7:0]              frame_count
);

  localparam int LINE_LEN  = H_ACTIVE + H_BLANK;
  localparam int MAX_LINES = max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
  localparam int PIX_W     = cnt_width(LINE_LEN);
  localparam int LINE_W    = cnt_width(MAX_LINES);

  localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(LINE_LEN - 1);
  localparam logic [PIX_W-1:0]  PIX_HACT    = PIX_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] SYNC_LAST   = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] BACK_LAST   = LINE_W'(V_BACK - 1);
  localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] FRONT_LAST  = LINE_W'(V_FRONT - 1);

  state_t            state_q, state_nxt;
  logic              pclk_q;
  logic              tick;
  logic [PIX_W-1:0]  pix_q, pix_nxt;
  logic [LINE_W-1:0] line_q, line_nxt;
  pattern_t          pat_q;
  logic [7:0]        const_q;
  logic [7:0]        frame_count_q;
  logic              frame_done_q;
  logic              vsync_q, href_q;
  logic [7:0]        d_q;
  logic              vsync_nxt, href_nxt;
  logic [7:0]        d_nxt;
  logic              line_end, last_line, frame_end, sync_entry;
  logic [7:0]        x_byte, y_byte, pat_byte;

  // PCLK falls on the clk edge where pclk_q is currently 1; every
  // frame-timing register advances only on that edge.
  assign tick     = pclk_q;
  assign line_end = (pix_q == PIX_LAST);

  always_comb begin
    last_line = 1'b0;
    case (state_q)
      SYNC:    last_line = (line_q == SYNC_LAST);
      BACK:    last_line = (line_q == BACK_LAST);
      ACTIVE:  last_line = (line_q == ACTIVE_LAST);
      FRONT:   last_line = (line_q == FRONT_LAST);
      default: last_line = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)   state_q <= IDLE;
    else if (tick) state_q <= state_nxt;
  end

  // Next-state logic (applied only on ticks)
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:   if (enable) state_nxt = SYNC;
      SYNC:   if (line_end && last_line) state_nxt = BACK;
      BACK:   if (line_end && last_line) state_nxt = ACTIVE;
      ACTIVE: if (line_end && last_line) state_nxt = FRONT;
      FRONT:  if (line_end && last_line) state_nxt = enable ? SYNC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / counter logic: everything here describes the position the
  // port will be at after the coming tick, so the registered outputs line
  // up with the registered state.
  always_comb begin
    pix_nxt  = '0;
    line_nxt = '0;
    if (state_q != IDLE) begin
      if (line_end) begin
        pix_nxt  = '0;
        line_nxt = (state_nxt != state_q) ? '0 : line_q + LINE_W'(1);
      end else begin
        pix_nxt  = pix_q + PIX_W'(1);
        line_nxt = line_q;
      end
    end
    vsync_nxt  = (state_nxt == SYNC);
    href_nxt   = (state_nxt == ACTIVE) && (pix_nxt < PIX_HACT);
    d_nxt      = href_nxt ? pat_byte : 8'h00;
    frame_end  = tick && (state_q == FRONT) && line_end && last_line;
    sync_entry = tick && (state_nxt == SYNC) && (state_q != SYNC);
  end

  // Counters can be narrower or wider than a byte; the pattern only ever
  // sees their low 8 bits.
  if (PIX_W >= 8) begin : g_x_trunc
    assign x_byte = pix_nxt[7:0];
  end else begin : g_x_ext
    assign x_byte = {{(8-PIX_W){1'b0}}, pix_nxt};
  end

  if (LINE_W >= 8) begin : g_y_trunc
    assign y_byte = line_nxt[7:0];
  end else begin : g_y_ext
    assign y_byte = {{(8-LINE_W){1'b0}}, line_nxt};
  end

  ov7670_pattern_gen u_pattern_gen (
    .pattern     (pat_q),
    .x           (x_byte),
    .y           (y_byte),
    .const_value (const_q),
    .frame_count (frame_count_q),
    .value       (pat_byte)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pclk_q        <= 1'b0;
      pix_q         <= '0;
      line_q        <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      d_q           <= 8'h00;
      pat_q         <= PAT_XRAMP;
      const_q       <= 8'h00;
      frame_count_q <= 8'h00;
      frame_done_q  <= 1'b0;
    end else begin
      pclk_q       <= ~pclk_q;
      frame_done_q <= frame_end;
      if (tick) begin
        pix_q   <= pix_nxt;
        line_q  <= line_nxt;
        vsync_q <= vsync_nxt;
        href_q  <= href_nxt;
        d_q     <= d_nxt;
      end
      // Pattern fields freeze for the whole frame at SYNC entry.
      if (sync_entry) begin
        pat_q   <= pattern_t'(pattern_sel);
        const_q <= const_value;
      end
      if (frame_end) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign cam.PCLK    = pclk_q;
  assign cam.VSYNC   = vsync_q;
  assign cam.HREF    = href_q;
  assign cam.D       = d_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ov7670_frame_emulator.sv
module tb_ov7670_frame_emulator;
  localparam int HA = 4, HB = 2, VA = 3, VS = 1, VB = 1, VF = 1;
  localparam int LINE = HA + HB;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] const_value = 8'h00;
  logic       frame_done;
  logic [7:0] frame_count;

  ov7670_frame_emulator_if cam_if();

  ov7670_frame_emulator #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .const_value (const_value),
    .cam         (cam_if.master),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  int pclk_idx, vs_cnt, vs_rise, first_vs_idx, first_href_idx, bursts, href_cnt, done_cnt;
  logic prev_vs = 1'b0, prev_href = 1'b0, prev_done = 1'b0;
  logic [7:0] exp_fc = 8'h00;
  logic expect_b2b = 1'b0;

  typedef struct packed {
    logic [1:0]  pat;
    logic [7:0]  cval;
    logic [95:0] bytes;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one sample per PCLK period (just after the tick edge) plus a
  // per-clk watch of frame_done.
  always @(negedge clk) begin
    if (reset_) begin
      if (prev_done) check("frame_done_width", {31'd0, frame_done}, 0);
      if (frame_done) begin
        done_cnt++;
        exp_fc = exp_fc + 8'd1;
        check("frame_count_at_done", {24'd0, frame_count}, {24'd0, exp_fc});
        check("vsync_at_done", {31'd0, cam_if.VSYNC}, {31'd0, expect_b2b});
        check("pclk_at_done", {31'd0, cam_if.PCLK}, 0);
      end
      prev_done = frame_done;
      if (!cam_if.PCLK) begin
        pclk_idx++;
        if (cam_if.VSYNC) vs_cnt++;
        if (cam_if.VSYNC && !prev_vs) begin
          vs_rise++;
          if (first_vs_idx < 0) first_vs_idx = pclk_idx;
        end
        if (cam_if.HREF && !prev_href) begin
          bursts++;
          if (first_href_idx < 0) first_href_idx = pclk_idx;
        end
        if (cam_if.HREF) begin
          href_cnt++;
          if (exp_q.size() == 0) check("d_unexpected_pixel", {31'd0, cam_if.HREF}, 0);
          else check("d_active", {24'd0, cam_if.D}, {24'd0, exp_q.pop_front()});
        end else begin
          check("d_blank", {24'd0, cam_if.D}, 0);
        end
        prev_vs   = cam_if.VSYNC;
        prev_href = cam_if.HREF;
      end
    end else begin
      prev_done = 1'b0;
      prev_vs   = 1'b0;
      prev_href = 1'b0;
    end
  end

  task automatic clear_meas();
    pclk_idx = 0; vs_cnt = 0; vs_rise = 0; first_vs_idx = -1;
    first_href_idx = -1; bursts = 0; href_cnt = 0; done_cnt = 0;
  endtask

  task automatic push_bytes(input logic [95:0] b);
    for (int k = 0; k < 12; k++) exp_q.push_back(b[95-8*k -: 8]);
  endtask

  // Raise enable just before a tick; VSYNC must be up right after it.
  task automatic start_frame(input logic hold);
    int n = 0;
    do begin @(negedge clk); n++; end while (cam_if.PCLK !== 1'b1 && n < 8);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency_vsync", {31'd0, cam_if.VSYNC}, 1);
    if (!hold) enable = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 200);
    check(name, {31'd0, frame_done}, 1);
  endtask

  task automatic wait_href();
    int n = 0;
    do begin @(negedge clk); n++; end while (cam_if.HREF !== 1'b1 && n < 200);
    check("wait_href", {31'd0, cam_if.HREF}, 1);
  endtask

  task automatic frame_checks(input int frames, input logic [7:0] fc);
    check("vsync_pclks", vs_cnt, frames * VS * LINE);
    check("vsync_rises", vs_rise, frames);
    check("first_href_delay", first_href_idx - first_vs_idx, (VS + VB) * LINE);
    check("href_bursts", bursts, frames * VA);
    check("href_pclks", href_cnt, frames * VA * HA);
    check("frame_done_pulses", done_cnt, frames);
    check("queue_drained", exp_q.size(), 0);
    check("frame_count_end", {24'd0, frame_count}, {24'd0, fc});
    check("idle_vsync", {31'd0, cam_if.VSYNC}, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_pclk;
    logic [7:0] base;

    vecs[0] = '{2'd0, 8'h00, 96'h00010203_00010203_00010203};
    vecs[1] = '{2'd1, 8'h00, 96'h00000000_01010101_02020202};
    vecs[2] = '{2'd2, 8'hA5, 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5};
    vecs[3] = '{2'd3, 8'h00, 96'h03020100_03020100_03020100};
    vecs[4] = '{2'd2, 8'h3C, 96'h3C3C3C3C_3C3C3C3C_3C3C3C3C};

    // Reset held with enable high.
    clear_meas();
    reset_ = 1'b0; enable = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_pclk", {31'd0, cam_if.PCLK}, 0);
    check("rst_vsync", {31'd0, cam_if.VSYNC}, 0);
    check("rst_href", {31'd0, cam_if.HREF}, 0);
    check("rst_d", {24'd0, cam_if.D}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_frame_count", {24'd0, frame_count}, 0);
    enable = 1'b0;
    reset_ = 1'b1;
    prev_pclk = cam_if.PCLK;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("pclk_toggle", {31'd0, cam_if.PCLK}, {31'd0, ~prev_pclk});
      check("idle_no_vsync", {31'd0, cam_if.VSYNC}, 0);
      prev_pclk = cam_if.PCLK;
    end

    // Single-frame table.
    for (int i = 0; i < 5; i++) begin
      pattern_sel = vecs[i].pat;
      const_value = vecs[i].cval;
      push_bytes(vecs[i].bytes);
      clear_meas();
      start_frame(1'b0);
      wait_done("single_done");
      repeat (40) @(negedge clk);
      frame_checks(1, 8'(i + 1));
    end

    // Pattern change mid-frame only affects the following frame.
    pattern_sel = 2'd0; const_value = 8'h00;
    push_bytes(96'h00010203_00010203_00010203);
    push_bytes(96'h5A5A5A5A_5A5A5A5A_5A5A5A5A);
    expect_b2b = 1'b1;
    clear_meas();
    start_frame(1'b1);
    wait_href();
    pattern_sel = 2'd2; const_value = 8'h5A;
    wait_done("midchg_done1");
    @(negedge clk);
    enable = 1'b0; expect_b2b = 1'b0;
    wait_done("midchg_done2");
    repeat (40) @(negedge clk);
    frame_checks(2, 8'd7);

    // Enable dropped in BACK: the frame still completes.
    pattern_sel = 2'd0;
    push_bytes(96'h00010203_00010203_00010203);
    clear_meas();
    start_frame(1'b1);
    repeat (12) @(negedge clk);
    check("in_back_vsync_low", {31'd0, cam_if.VSYNC}, 0);
    enable = 1'b0;
    wait_done("stop_done");
    repeat (60) @(negedge clk);
    frame_checks(1, 8'd8);

    // 257 back-to-back frames of pattern 3; frame_count wraps through 0.
    base = exp_fc;
    for (int f = 0; f < 257; f++)
      for (int b = 0; b < 12; b++)
        exp_q.push_back(8'(b % 4) ^ 8'(base + 8'(f)));
    pattern_sel = 2'd3;
    expect_b2b = 1'b1;
    clear_meas();
    start_frame(1'b1);
    for (int f = 0; f < 256; f++) wait_done("cont_done");
    @(negedge clk);
    enable = 1'b0; expect_b2b = 1'b0;
    wait_done("cont_last_done");
    repeat (40) @(negedge clk);
    frame_checks(257, 8'(base + 8'd1));

    // Reset asserted during ACTIVE clears outputs at once.
    pattern_sel = 2'd0;
    push_bytes(96'h00010203_00010203_00010203);
    clear_meas();
    start_frame(1'b0);
    wait_href();
    reset_ = 1'b0;
    #1;
    check("midrst_href", {31'd0, cam_if.HREF}, 0);
    check("midrst_d", {24'd0, cam_if.D}, 0);
    check("midrst_vsync", {31'd0, cam_if.VSYNC}, 0);
    check("midrst_pclk", {31'd0, cam_if.PCLK}, 0);
    check("midrst_frame_count", {24'd0, frame_count}, 0);
    exp_q.delete();
    exp_fc = 8'h00;
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle_vsync", {31'd0, cam_if.VSYNC}, 0);
    check("post_rst_frame_count", {24'd0, frame_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
